// File: rtl/wrr_vc_scheduler_pkg.sv
// Shared constants, state encoding and index helper for the weighted round-robin VC scheduler.
package wrr_vc_scheduler_pkg;

  localparam logic [1:0] VCHANEL0 = 2'b00;
  localparam logic [1:0] VCHANEL1 = 2'b01;
  localparam logic [1:0] VCHANEL2 = 2'b10;
  localparam logic [1:0] VCHANEL3 = 2'b11;

  localparam int         DATA_W_DEF   = 4;
  localparam int         WGT_W_DEF    = 3;
  localparam logic [3:0] INACTIVE_DEF = 4'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // VC indices wrap modulo 4, so a 2-bit add is the whole rotation.
  function automatic logic [1:0] vc_wrap(input logic [1:0] base, input logic [1:0] step);
    return base + step;
  endfunction

endpackage

// File: rtl/wrr_vc_scheduler_if.sv
// Bundle of VC FIFO bank, weight and downstream signals seen by the scheduler.
interface wrr_vc_scheduler_if #(
  parameter int DATA_W = 4,
  parameter int WGT_W  = 3
);
  logic              enb;
  logic              pause;
  logic              empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3;
  logic [DATA_W-1:0] out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3;
  logic [WGT_W-1:0]  wgt_vc0, wgt_vc1, wgt_vc2, wgt_vc3;
  logic              pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3;
  logic [1:0]        arbiter_sel;
  logic [DATA_W-1:0] out_wrr;
  logic              valid_wrr;
  logic              idle;

  modport master (
    input  enb, pause,
    input  empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    input  out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
    input  wgt_vc0, wgt_vc1, wgt_vc2, wgt_vc3,
    output pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    output arbiter_sel, out_wrr, valid_wrr, idle
  );

  modport slave (
    output enb, pause,
    output empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    output out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
    output wgt_vc0, wgt_vc1, wgt_vc2, wgt_vc3,
    input  pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    input  arbiter_sel, out_wrr, valid_wrr, idle
  );

endinterface

// File: rtl/wrr_vc_scheduler_next_vc.sv
// Rotating-priority finder: first eligible VC scanning upward from last+1, last itself lowest.
module wrr_next_vc
  import wrr_vc_scheduler_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] next
);

  // Descending scan so the smallest offset from last is written last and wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found = 1'b0;
    next  = last;
    for (int i = 4; i >= 1; i--) begin
      if (eligible[vc_wrap(last, 2'(i))]) begin
        found = 1'b1;
        next  = vc_wrap(last, 2'(i));
      end
    end
  end

endmodule

// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler draining four VC FIFOs onto one registered output lane.
module wrr_vc_scheduler
  import wrr_vc_scheduler_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                WGT_W    = WGT_W_DEF,
  parameter logic [DATA_W-1:0] INACTIVE = DATA_W'(INACTIVE_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  wrr_vc_scheduler_if.master  bus
);

  logic [3:0]        w_empty;
  logic [3:0]        w_eligible;
  logic [WGT_W-1:0]  w_wgt [4];
  logic [DATA_W-1:0] w_data [4];

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sel, w_sel_nxt;
  logic [1:0]        r_last, w_last_nxt;
  logic [WGT_W-1:0]  r_credit, w_credit_nxt;
  logic [1:0]        w_scan_from;
  logic              w_found;
  logic [1:0]        w_next;
  logic              w_pop_ok, w_pop, w_turn_end;

  logic              r_pop_d;
  logic [1:0]        r_sel_d;
  logic [DATA_W-1:0] r_out;
  logic              r_valid;

  assign w_empty   = {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
  assign w_wgt[0]  = bus.wgt_vc0;
  assign w_wgt[1]  = bus.wgt_vc1;
  assign w_wgt[2]  = bus.wgt_vc2;
  assign w_wgt[3]  = bus.wgt_vc3;
  assign w_data[0] = bus.out_vchanel0;
  assign w_data[1] = bus.out_vchanel1;
  assign w_data[2] = bus.out_vchanel2;
  assign w_data[3] = bus.out_vchanel3;

  always_comb begin
    for (int i = 0; i < 4; i++) w_eligible[i] = !w_empty[i] && (w_wgt[i] != '0);
  end

  // In SERVE the current VC is the scan origin, making it lowest priority at hand-off.
  assign w_scan_from = (r_state == SERVE) ? r_sel : r_last;

  wrr_next_vc u_next_vc (
    .eligible (w_eligible),
    .last     (w_scan_from),
    .found    (w_found),
    .next     (w_next)
  );

  assign w_pop_ok   = bus.enb && !bus.pause && !rst;
  assign w_pop      = (r_state == SERVE) && w_pop_ok && !w_empty[r_sel] && (r_credit != '0);
  assign w_turn_end = (r_state == SERVE) && w_pop_ok &&
                      (w_empty[r_sel] || (r_credit <= WGT_W'(1)));

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_last_nxt   = r_last;
    w_credit_nxt = r_credit;
    case (r_state)
      IDLE: begin
        if (bus.enb && w_found) begin
          w_state_nxt  = SERVE;
          w_sel_nxt    = w_next;
          w_credit_nxt = w_wgt[w_next];
        end
      end
      SERVE: begin
        if (w_turn_end) begin
          w_last_nxt = r_sel;
          if (w_found) begin
            w_sel_nxt    = w_next;
            w_credit_nxt = w_wgt[w_next];
          end else begin
            w_state_nxt  = IDLE;
            w_credit_nxt = '0;
          end
        end else if (w_pop) begin
          w_credit_nxt = r_credit - WGT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset leaves last=VC3 so the first scan after reset starts at VC0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= VCHANEL0;
      r_last   <= VCHANEL3;
      r_credit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_last   <= w_last_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  // FIFO data lands one cycle after its pop, so the mux uses sel delayed by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_d <= 1'b0;
      r_sel_d <= VCHANEL0;
      r_out   <= INACTIVE;
      r_valid <= 1'b0;
    end else begin
      r_pop_d <= w_pop;
      r_sel_d <= r_sel;
      r_valid <= r_pop_d;
      r_out   <= r_pop_d ? w_data[r_sel_d] : INACTIVE;
    end
  end

  assign bus.pop_vchanel0 = w_pop && (r_sel == VCHANEL0);
  assign bus.pop_vchanel1 = w_pop && (r_sel == VCHANEL1);
  assign bus.pop_vchanel2 = w_pop && (r_sel == VCHANEL2);
  assign bus.pop_vchanel3 = w_pop && (r_sel == VCHANEL3);
  assign bus.arbiter_sel  = r_sel;
  assign bus.out_wrr      = r_out;
  assign bus.valid_wrr    = r_valid;
  assign bus.idle         = (r_state == IDLE);

endmodule

// File: tb/tb_wrr_vc_scheduler.sv
// Directed bench for wrr_vc_scheduler: FIFO-bank model, per-cycle logs, hand-computed pop orders.
module tb_wrr_vc_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;

  int fill_cnt [4];
  int rd_cnt   [4];

  int pop_log[$];
  int valid_log[$];
  int out_log[$];
  int sel_log[$];
  int idle_log[$];

  always #5 clk = ~clk;

  wrr_vc_scheduler_if #(.DATA_W(4), .WGT_W(3)) bus ();

  wrr_vc_scheduler #(.DATA_W(4), .WGT_W(3), .INACTIVE(4'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Word k of VC v is {v, k[1:0]}, so every popped word names its source.
  function automatic logic [3:0] word_of(input int vc, input int k);
    logic [1:0] v;
    logic [1:0] kk;
    v  = 2'(vc);
    kk = 2'(k);
    return {v, kk};
  endfunction

  task automatic set_out(input int i, input logic [3:0] d);
    case (i)
      0: bus.out_vchanel0 = d;
      1: bus.out_vchanel1 = d;
      2: bus.out_vchanel2 = d;
      default: bus.out_vchanel3 = d;
    endcase
  endtask

  task automatic drive_fifo();
    bus.empty_vchanel0 = (rd_cnt[0] >= fill_cnt[0]);
    bus.empty_vchanel1 = (rd_cnt[1] >= fill_cnt[1]);
    bus.empty_vchanel2 = (rd_cnt[2] >= fill_cnt[2]);
    bus.empty_vchanel3 = (rd_cnt[3] >= fill_cnt[3]);
  endtask

  // One clock: sample at negedge, then apply the model FIFO pops 1 time unit after posedge.
  task automatic cycle();
    logic [3:0] pops;
    logic [3:0] empt;
    int         enc;
    @(negedge clk);
    pops = {bus.pop_vchanel3, bus.pop_vchanel2, bus.pop_vchanel1, bus.pop_vchanel0};
    empt = {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
    if ($countones(pops) > 1 || (pops & empt) != 4'b0) viol++;
    enc = -1;
    for (int i = 0; i < 4; i++) if (pops[i]) enc = (enc == -1) ? i : 9;
    pop_log.push_back(enc);
    valid_log.push_back(int'(bus.valid_wrr));
    out_log.push_back(int'(bus.out_wrr));
    sel_log.push_back(int'(bus.arbiter_sel));
    idle_log.push_back(int'(bus.idle));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pops[i] && rd_cnt[i] < fill_cnt[i]) begin
        set_out(i, word_of(i, rd_cnt[i]));
        rd_cnt[i]++;
      end
    end
    drive_fifo();
  endtask

  task automatic clear_logs();
    pop_log.delete();
    valid_log.delete();
    out_log.delete();
    sel_log.delete();
    idle_log.delete();
    viol = 0;
  endtask

  task automatic reset_dut(input int w0, input int w1, input int w2, input int w3,
                           input int f0, input int f1, input int f2, input int f3);
    rst = 1'b1;
    bus.enb   = 1'b1;
    bus.pause = 1'b0;
    bus.wgt_vc0 = 3'(w0);
    bus.wgt_vc1 = 3'(w1);
    bus.wgt_vc2 = 3'(w2);
    bus.wgt_vc3 = 3'(w3);
    fill_cnt[0] = f0;
    fill_cnt[1] = f1;
    fill_cnt[2] = f2;
    fill_cnt[3] = f3;
    for (int i = 0; i < 4; i++) begin
      rd_cnt[i] = 0;
      set_out(i, 4'b0);
    end
    drive_fifo();
    clear_logs();
    cycle();
    cycle();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    clear_logs();
  endtask

  // Pops must match exp_pop; each pop at cycle c shows up on out_wrr at c+2.
  task automatic check_run(input string name, input int exp_pop[$]);
    int n;
    int cnt [4];
    int ev  [64];
    int ed  [64];
    n = exp_pop.size();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 64; c++) begin
      ev[c] = 0;
      ed[c] = 0;
    end
    for (int c = 0; c < n; c++) begin
      if (exp_pop[c] >= 0) begin
        ev[c+2] = 1;
        ed[c+2] = int'(word_of(exp_pop[c], cnt[exp_pop[c]]));
        cnt[exp_pop[c]]++;
      end
    end
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s pop[%0d]", name, c), pop_log[c], exp_pop[c]);
      check($sformatf("%s valid[%0d]", name, c), valid_log[c], ev[c]);
      check($sformatf("%s out[%0d]", name, c), out_log[c], ev[c] != 0 ? ed[c] : 0);
    end
    check($sformatf("%s invariant", name), viol, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];

    // Reset held two cycles with every VC non-empty.
    reset_dut(1, 1, 1, 1, 8, 8, 8, 8);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("reset pop[%0d]", c), pop_log[c], -1);
      check($sformatf("reset valid[%0d]", c), valid_log[c], 0);
      check($sformatf("reset out[%0d]", c), out_log[c], 0);
      check($sformatf("reset idle[%0d]", c), idle_log[c], 1);
      check($sformatf("reset sel[%0d]", c), sel_log[c], 0);
    end

    // Equal weights: strict rotation, first word out in cycle 3.
    release_reset();
    repeat (10) cycle();
    exp_q = '{-1, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    check_run("w1111", exp_q);

    // Weights 3,1,0,2: VC2 skipped, bursts hand off without bubbles.
    reset_dut(3, 1, 0, 2, 8, 8, 8, 8);
    release_reset();
    repeat (13) cycle();
    exp_q = '{-1, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    check_run("w3102", exp_q);

    // VC1 weight 4 with 2 words: turn ends on empty, credit forfeited, VC2 takes over.
    reset_dut(1, 4, 1, 1, 0, 2, 3, 0);
    release_reset();
    repeat (9) cycle();
    exp_q = '{-1, 1, 1, -1, 2, 2, 2, -1, -1};
    check_run("drain", exp_q);
    check("drain sel[3]", sel_log[3], 1);
    check("drain sel[4]", sel_log[4], 2);
    check("drain idle[3]", idle_log[3], 0);
    check("drain idle[8]", idle_log[8], 1);

    // Pause for 3 cycles with VC0 holding 2 credits.
    reset_dut(3, 1, 1, 1, 8, 8, 8, 8);
    release_reset();
    for (int c = 0; c < 10; c++) begin
      bus.pause = (c >= 2 && c <= 4);
      cycle();
    end
    bus.pause = 1'b0;
    exp_q = '{-1, 0, -1, -1, -1, 0, 0, 1, 2, 3};
    check_run("pause", exp_q);
    check("pause sel[3]", sel_log[3], 0);

    // Reset pulse the cycle after a pop: that word never appears, VC0 served first again.
    reset_dut(1, 1, 1, 1, 8, 8, 8, 8);
    release_reset();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    exp_q = '{-1, 0, -1, -1, 0, 1, 2};
    for (int c = 0; c < 7; c++) begin
      check($sformatf("rstpulse pop[%0d]", c), pop_log[c], exp_q[c]);
      check($sformatf("rstpulse valid[%0d]", c), valid_log[c], (c == 6) ? 1 : 0);
    end
    check("rstpulse out[3]", out_log[3], 0);
    check("rstpulse out[6]", out_log[6], int'(word_of(0, 1)));
    check("rstpulse idle[3]", idle_log[3], 1);
    check("rstpulse invariant", viol, 0);

    // All weights zero: never leaves IDLE.
    reset_dut(0, 0, 0, 0, 8, 8, 8, 8);
    release_reset();
    repeat (6) cycle();
    exp_q = '{-1, -1, -1, -1, -1, -1};
    check_run("w0000", exp_q);
    check("w0000 idle[5]", idle_log[5], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
